ifetch_controller: RTL and testbench

- Sequences instruction fetch from the byte-addressed, little-endian 32-bit instruction memory.
- Owns the program counter and issues word-aligned fetch requests over a req/ack port, tolerating 0..N cycle memory latency.
- Presents each fetched word to decode over a valid/ready handshake.
- Handles branch redirects, including squashing an in-flight fetch, and flags end-of-memory and misaligned-target conditions.

---
 rtl/ifetch_if.sv | 42 ++++
 rtl/ifetch_controller.sv | 147 ++++++++++++++
 tb/tb_ifetch_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Bundle of the fetch controller's memory port, decode port, redirect port
// and status outputs. The controller binds the master modport; whatever
// models memory, decode and the branch unit binds the slave modport.
//
// Handshakes:
//   imem_req/imem_ack : imem_req rises with imem_addr and both stay stable
//                       until the cycle where imem_ack=1 (which may be the
//                       first request cycle). imem_rdata is only sampled in
//                       an ack cycle. Only one request is ever outstanding.
//   inst_valid/inst_ready : a word moves to decode in a cycle where both are
//                       1. While inst_valid=1 and inst_ready=0, inst and
//                       inst_pc hold their values.
interface ifetch_if #(
    parameter int ADDR_W = 64
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;
    logic              fault;
    logic [31:0]       fetch_count;
    logic [2:0]        dbg_state;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
               halted, fault, fetch_count, dbg_state,
        input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
               halted, fault, fetch_count, dbg_state,
        output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues word fetches to a
// variable-latency memory, hands each word to decode, and handles branch
// redirects (including squashing a fetch already in flight), end of
// memory and bad redirect targets.
module ifetch_controller #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                MEM_BYTES = 32
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_VALID = 3'd1,
        S_DRAIN = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       count_q, count_d;

    logic xfer;
    logic redirect_ok;

    // A word at address a is fetchable when its last byte a+3 lies inside
    // the memory. The sum is formed one bit wider so addresses near the
    // top of the address space cannot wrap around and look in range.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, a} + (ADDR_W+1)'(3);
        return last_byte < (ADDR_W+1)'(MEM_BYTES);
    endfunction

    assign xfer        = (state_q == S_VALID) && bus.inst_ready;
    assign redirect_ok = (bus.redirect_pc[1:0] == 2'b00) && in_range(bus.redirect_pc);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            count_q      <= count_d;
        end
    end

    // Next-state logic. A redirect beats every other event in the same
    // cycle; the only thing that still happens alongside it is counting a
    // decode transfer that completes in that cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        count_d      = xfer ? (count_q + 32'd1) : count_q;

        case (state_q)
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                    if (!redirect_ok) begin
                        state_d = S_FAULT;
                    end else if (bus.imem_ack) begin
                        // Data for the old PC arrived this cycle: drop it.
                        state_d = S_FETCH;
                    end else begin
                        // Request still in flight: keep presenting the old
                        // address until memory answers, then discard.
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (bus.imem_ack) begin
                    inst_d    = bus.imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + ADDR_W'(4);
                    state_d   = S_VALID;
                end
            end

            S_VALID: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    state_d = redirect_ok ? S_FETCH : S_FAULT;
                end else if (xfer) begin
                    state_d = in_range(pc_q) ? S_FETCH : S_HALT;
                end
            end

            S_DRAIN: begin
                if (bus.redirect_valid) begin
                    // Latest redirect wins; the old request still drains.
                    pc_d = bus.redirect_pc;
                    if (!redirect_ok) begin
                        state_d = S_FAULT;
                    end else if (bus.imem_ack) begin
                        state_d = S_FETCH;
                    end
                end else if (bus.imem_ack) begin
                    state_d = S_FETCH;
                end
            end

            S_HALT, S_FAULT: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    state_d = redirect_ok ? S_FETCH : S_FAULT;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
        bus.imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
        bus.inst_valid  = (state_q == S_VALID);
        bus.inst        = inst_q;
        bus.inst_pc     = inst_pc_q;
        bus.halted      = (state_q == S_HALT);
        bus.fault       = (state_q == S_FAULT);
        bus.fetch_count = count_q;
        bus.dbg_state   = state_q;
    end

endmodule

// File: tb/tb_ifetch_controller.sv
// Directed bench for ifetch_controller: a per-cycle table of inputs and
// expected outputs, followed by a free-running zero-latency memory sequence.
module tb_ifetch_controller;

    localparam int ADDR_W    = 64;
    localparam int MEM_BYTES = 32;

    localparam logic [31:0] W0 = 32'h8b1f03e5;
    localparam logic [31:0] W1 = 32'hf84000a4;
    localparam logic [31:0] W2 = 32'h8b040086;
    localparam logic [31:0] W3 = 32'hf80010a6;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
        logic        e_halt;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    logic clk;
    logic rst;

    ifetch_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch_controller #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (64'h0),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          row   = 0;
    vec_t        vq[$];
    vec_t        cur;
    logic [31:0] mem [8];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    // Expected outputs for the cycle being built.
    task automatic ex(input logic req, input logic [63:0] addr, input logic val,
                      input logic [31:0] inst, input logic [63:0] ipc,
                      input logic h, input logic f, input logic [31:0] cnt);
        cur.chk     = 1'b1;
        cur.e_req   = req;
        cur.e_addr  = addr;
        cur.e_val   = val;
        cur.e_inst  = inst;
        cur.e_ipc   = ipc;
        cur.e_halt  = h;
        cur.e_fault = f;
        cur.e_cnt   = cnt;
    endtask

    // Inputs driven during that cycle; completes and queues the row.
    task automatic in(input logic r, input logic ack, input logic [31:0] rdata,
                      input logic rdy, input logic rv, input logic [63:0] rpc);
        cur.rst   = r;
        cur.ack   = ack;
        cur.rdata = rdata;
        cur.rdy   = rdy;
        cur.rv    = rv;
        cur.rpc   = rpc;
        vq.push_back(cur);
        cur.chk = 1'b0;
    endtask

    task automatic drive(input logic r, input logic ack, input logic [31:0] rdata,
                         input logic rdy, input logic rv, input logic [63:0] rpc);
        rst                = r;
        bus.imem_ack       = ack;
        bus.imem_rdata     = rdata;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic check_outputs(input vec_t v);
        cmp("imem_req", 64'(bus.imem_req), 64'(v.e_req));
        if (v.e_req) cmp("imem_addr", bus.imem_addr, v.e_addr);
        cmp("inst_valid", 64'(bus.inst_valid), 64'(v.e_val));
        cmp("inst", 64'(bus.inst), 64'(v.e_inst));
        cmp("inst_pc", bus.inst_pc, v.e_ipc);
        cmp("halted", 64'(bus.halted), 64'(v.e_halt));
        cmp("fault", 64'(bus.fault), 64'(v.e_fault));
        cmp("fetch_count", 64'(bus.fetch_count), 64'(v.e_cnt));
    endtask

    initial begin
        logic [31:0] prev_inst;
        logic [63:0] prev_pc;
        int          n;
        int          cyc;

        mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;
        mem[4] = '0; mem[5] = '0; mem[6] = '0; mem[7] = '0;
        cur = '{default: '0};
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // ---- vector table ----
        in(1, 0, 0, 0, 0, 0);
        // Straight line, zero-latency memory, decode always ready.
        for (int k = 0; k < 8; k++) begin
            prev_inst = (k == 0) ? 32'h0 : mem[k-1];
            prev_pc   = (k == 0) ? 64'h0 : 64'(4 * (k - 1));
            ex(1, 64'(4 * k), 0, prev_inst, prev_pc, 0, 0, 32'(k)); in(0, 1, mem[k], 1, 0, 0);
            ex(0, 0, 1, mem[k], 64'(4 * k), 0, 0, 32'(k));          in(0, 0, 0, 1, 0, 0);
        end
        ex(0, 0, 0, 0, 28, 1, 0, 8);  in(0, 0, 0, 1, 0, 0);
        // Out of HALT with a redirect to 0.
        ex(0, 0, 0, 0, 28, 1, 0, 8);  in(0, 0, 0, 1, 1, 0);
        ex(1, 0, 0, 0, 28, 0, 0, 8);  in(0, 1, W0, 1, 0, 0);
        // Transfer and redirect to 8 in the same cycle.
        ex(0, 0, 1, W0, 0, 0, 0, 8);  in(0, 0, 0, 1, 1, 8);
        // Three cycles of memory latency, then decode stalls twice.
        ex(1, 8, 0, W0, 0, 0, 0, 9);  in(0, 0, 0, 1, 0, 0);
        ex(1, 8, 0, W0, 0, 0, 0, 9);  in(0, 0, 0, 0, 0, 0);
        ex(1, 8, 0, W0, 0, 0, 0, 9);  in(0, 0, 0, 0, 0, 0);
        ex(1, 8, 0, W0, 0, 0, 0, 9);  in(0, 1, W2, 1, 0, 0);
        ex(0, 0, 1, W2, 8, 0, 0, 9);  in(0, 0, 0, 0, 0, 0);
        ex(0, 0, 1, W2, 8, 0, 0, 9);  in(0, 0, 0, 0, 0, 0);
        ex(0, 0, 1, W2, 8, 0, 0, 9);  in(0, 0, 0, 1, 0, 0);
        ex(1, 12, 0, W2, 8, 0, 0, 10); in(0, 1, W3, 0, 0, 0);
        // Reset while a word waits in VALID.
        ex(0, 0, 1, W3, 12, 0, 0, 10); in(1, 0, 0, 0, 0, 0);
        ex(1, 0, 0, 0, 0, 0, 0, 0);   in(0, 1, W0, 1, 0, 0);
        ex(0, 0, 1, W0, 0, 0, 0, 0);  in(0, 0, 0, 1, 0, 0);
        // Redirect to 16 in the first latency cycle of the fetch at 4.
        ex(1, 4, 0, W0, 0, 0, 0, 1);  in(0, 0, 0, 1, 1, 16);
        ex(1, 4, 0, W0, 0, 0, 0, 1);  in(0, 0, 0, 1, 0, 0);
        ex(1, 4, 0, W0, 0, 0, 0, 1);  in(0, 1, 32'hdeadbeef, 1, 0, 0);
        ex(1, 16, 0, W0, 0, 0, 0, 1); in(0, 1, 0, 1, 0, 0);
        ex(0, 0, 1, 0, 16, 0, 0, 1);  in(0, 0, 0, 1, 0, 0);
        // Enter DRAIN, then reset during it.
        ex(1, 20, 0, 0, 16, 0, 0, 2); in(0, 0, 0, 1, 1, 4);
        ex(1, 20, 0, 0, 16, 0, 0, 2); in(1, 0, 0, 1, 0, 0);
        // Bad targets: misaligned, then past the end, then a good one.
        ex(1, 0, 0, 0, 0, 0, 0, 0);   in(0, 0, 0, 1, 1, 6);
        ex(0, 0, 0, 0, 0, 0, 1, 0);   in(0, 0, 0, 1, 1, 32);
        ex(0, 0, 0, 0, 0, 0, 1, 0);   in(0, 0, 0, 1, 0, 0);
        ex(0, 0, 0, 0, 0, 0, 1, 0);   in(0, 0, 0, 1, 1, 12);
        ex(1, 12, 0, 0, 0, 0, 0, 0);  in(0, 1, W3, 1, 0, 0);
        ex(0, 0, 1, W3, 12, 0, 0, 0); in(0, 0, 0, 1, 0, 0);
        // Two redirects during DRAIN: the second (8) wins.
        ex(1, 16, 0, W3, 12, 0, 0, 1); in(0, 0, 0, 1, 1, 24);
        ex(1, 16, 0, W3, 12, 0, 0, 1); in(0, 0, 0, 1, 1, 8);
        ex(1, 16, 0, W3, 12, 0, 0, 1); in(0, 1, 32'h12345678, 1, 0, 0);
        ex(1, 8, 0, W3, 12, 0, 0, 1);  in(0, 1, W2, 1, 0, 0);
        ex(0, 0, 1, W2, 8, 0, 0, 1);   in(0, 0, 0, 1, 0, 0);
        // Redirect to 28, the last in-range word; its transfer halts.
        ex(1, 12, 0, W2, 8, 0, 0, 2);  in(0, 0, 0, 1, 1, 28);
        ex(1, 12, 0, W2, 8, 0, 0, 2);  in(0, 1, 0, 1, 0, 0);
        ex(1, 28, 0, W2, 8, 0, 0, 2);  in(0, 1, 32'hcafef00d, 1, 0, 0);
        ex(0, 0, 1, 32'hcafef00d, 28, 0, 0, 2); in(0, 0, 0, 1, 0, 0);
        // Aligned target at the top of the address space must fault.
        ex(0, 0, 0, 32'hcafef00d, 28, 1, 0, 3); in(0, 0, 0, 1, 1, 64'hffff_ffff_ffff_fffc);
        ex(0, 0, 0, 32'hcafef00d, 28, 0, 1, 3); in(0, 0, 0, 1, 1, 0);
        // Ack and redirect together in FETCH: data dropped, refetch at 4.
        ex(1, 0, 0, 32'hcafef00d, 28, 0, 0, 3); in(0, 1, W0, 1, 1, 4);
        ex(1, 4, 0, 32'hcafef00d, 28, 0, 0, 3); in(0, 1, W1, 1, 0, 0);
        ex(0, 0, 1, W1, 4, 0, 0, 3);   in(0, 0, 0, 1, 0, 0);
        ex(1, 8, 0, W1, 4, 0, 0, 4);   in(0, 0, 0, 0, 0, 0);

        // ---- apply table ----
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            row = i;
            if (vq[i].chk) check_outputs(vq[i]);
            drive(vq[i].rst, vq[i].ack, vq[i].rdata, vq[i].rdy, vq[i].rv, vq[i].rpc);
        end

        // ---- free-running zero-latency memory until halt ----
        @(negedge clk);
        row = -1;
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        n   = 0;
        cyc = 0;
        while (!bus.halted && cyc < 100) begin
            if (bus.inst_valid) begin
                cmp("run inst_pc", bus.inst_pc, 64'(4 * n));
                cmp("run inst", 64'(bus.inst), 64'(mem[n % 8]));
                n++;
            end
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = (bus.imem_addr < 64'(MEM_BYTES)) ? mem[bus.imem_addr[4:2]] : 32'h0;
            @(negedge clk);
            cyc++;
        end
        bus.imem_ack = 1'b0;
        cmp("run halted (cycle bound)", 64'(bus.halted), 64'd1);
        cmp("run transfers", 64'(n), 64'd8);
        cmp("run fetch_count", 64'(bus.fetch_count), 64'd8);
        @(negedge clk);
        cmp("run imem_req after halt", 64'(bus.imem_req), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
